// File: rtl/framebuffer_row_reader.sv
// Reads one display row pair (row r and r+HALF_ROWS) from framebuffer port B
// and streams the paired RGB565 pixels per column over a valid/ready handshake.
module framebuffer_row_reader #(
  parameter int unsigned COLS      = 64,
  parameter int unsigned HALF_ROWS = 16,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                         Clock,
  input  logic                         ResetN,
  input  logic                         Start,
  input  logic [$clog2(HALF_ROWS)-1:0] RowIndex,
  output logic [ADDR_W-1:0]            AddressB,
  output logic                         ClockEnB,
  input  logic [DATA_W-1:0]            QB,
  output logic                         PixelValid,
  input  logic                         PixelReady,
  output logic [DATA_W-1:0]            PixelTop,
  output logic [DATA_W-1:0]            PixelBottom,
  output logic [$clog2(COLS)-1:0]      PixelCol,
  output logic                         Busy,
  output logic                         Done
);

  localparam int unsigned COL_W    = $clog2(COLS);
  localparam int unsigned ROW_W    = $clog2(HALF_ROWS);
  localparam int unsigned LAST_COL = COLS - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_TOP  = 3'd1,
    S_RD_BOT  = 3'd2,
    S_CAP_BOT = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cen;
  logic                r_valid;
  logic [DATA_W-1:0]   r_top;
  logic [DATA_W-1:0]   r_bot;
  logic [COL_W-1:0]    r_pcol;
  logic                r_busy;
  logic                r_done;

  logic [COL_W-1:0]    w_col_nxt;
  logic [ROW_W-1:0]    w_row_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_cen_nxt;
  logic                w_valid_nxt;
  logic [DATA_W-1:0]   w_top_nxt;
  logic [DATA_W-1:0]   w_bot_nxt;
  logic [COL_W-1:0]    w_pcol_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_hs;
  logic                w_last;
  logic                w_accept;

  assign w_hs     = (r_state == S_PRESENT) && r_valid && PixelReady;
  assign w_last   = (r_col == COL_W'(LAST_COL));
  assign w_accept = (r_state == S_IDLE) && Start;

  // State register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (Start) w_state_nxt = S_RD_TOP;
      S_RD_TOP:  w_state_nxt = S_RD_BOT;
      S_RD_BOT:  w_state_nxt = S_CAP_BOT;
      S_CAP_BOT: w_state_nxt = S_PRESENT;
      S_PRESENT: if (w_hs) w_state_nxt = w_last ? S_IDLE : S_RD_TOP;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, keyed on the state being entered
  always_comb begin
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_addr_nxt  = r_addr;
    w_top_nxt   = r_top;
    w_bot_nxt   = r_bot;
    w_pcol_nxt  = r_pcol;
    w_done_nxt  = 1'b0;

    if (w_accept) begin
      w_row_nxt = RowIndex;
      w_col_nxt = '0;
    end else if (w_hs && !w_last) begin
      w_col_nxt = r_col + COL_W'(1);
    end

    // Top half occupies the lower half of the address space; the MSB selects the bottom half
    if (w_state_nxt == S_RD_TOP) begin
      w_addr_nxt = ADDR_W'({1'b0, w_row_nxt, w_col_nxt});
    end else if (w_state_nxt == S_RD_BOT) begin
      w_addr_nxt = ADDR_W'({1'b1, r_row, r_col});
    end

    if (r_state == S_RD_BOT) begin
      w_top_nxt = QB;
    end
    if (r_state == S_CAP_BOT) begin
      w_bot_nxt  = QB;
      w_pcol_nxt = r_col;
    end

    w_cen_nxt   = (w_state_nxt == S_RD_TOP) || (w_state_nxt == S_RD_BOT);
    w_valid_nxt = (w_state_nxt == S_PRESENT);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    if (w_hs && w_last) begin
      w_done_nxt = 1'b1;
    end
  end

  // Output and datapath registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_cen   <= 1'b0;
      r_valid <= 1'b0;
      r_top   <= '0;
      r_bot   <= '0;
      r_pcol  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_addr  <= w_addr_nxt;
      r_cen   <= w_cen_nxt;
      r_valid <= w_valid_nxt;
      r_top   <= w_top_nxt;
      r_bot   <= w_bot_nxt;
      r_pcol  <= w_pcol_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign AddressB    = r_addr;
  assign ClockEnB    = r_cen;
  assign PixelValid  = r_valid;
  assign PixelTop    = r_top;
  assign PixelBottom = r_bot;
  assign PixelCol    = r_pcol;
  assign Busy        = r_busy;
  assign Done        = r_done;

endmodule
